// File: rtl/filter_peak_detector.sv
// Threshold-crossing pulse detector on the shaping-filter output: tracks pulse maximum and
// emits {amplitude, timestamp, width} records. Optional pile-up rejection: PEAK_PILEUP_REJECT_EN.
module filter_peak_detector #(
    parameter int unsigned DATA_W    = 20,
    parameter int unsigned TS_W      = 32,
    parameter int unsigned W_W       = 8,
    parameter int unsigned MIN_WIDTH = 3,
    parameter int unsigned HOLDOFF   = 16,
    parameter int unsigned MAX_WIDTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] filter_data,
    input  logic [DATA_W-1:0] thr,
    input  logic              peak_ready,
    output logic              peak_valid,
    output logic [DATA_W-1:0] peak_amp,
    output logic [TS_W-1:0]   peak_time,
    output logic [W_W-1:0]    peak_width,
    output logic              busy,
    output logic [7:0]        lost_cnt,
    output logic [7:0]        pileup_cnt
);

`ifdef PEAK_PILEUP_REJECT_EN
    localparam bit PILEUP_EN = 1'b1;
`else
    localparam bit PILEUP_EN = 1'b0;
`endif

    localparam logic [W_W-1:0] WIDTH_SAT = {W_W{1'b1}};
    localparam logic [7:0]     CNT_SAT   = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RISE = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                    r_state;
    logic signed [DATA_W-1:0]  r_d;
    logic signed [DATA_W-1:0]  r_d_prev;
    logic signed [DATA_W-1:0]  r_thr;
    logic signed [DATA_W-1:0]  r_max;
    logic [TS_W-1:0]           r_ts;
    logic [TS_W-1:0]           r_tmax;
    logic [W_W-1:0]            r_width;
    logic [W_W-1:0]            r_hold;
    logic                      r_busy;
    logic                      r_peak_valid;
    logic [DATA_W-1:0]         r_peak_amp;
    logic [TS_W-1:0]           r_peak_time;
    logic [W_W-1:0]            r_peak_width;
    logic [7:0]                r_lost_cnt;
    logic [7:0]                r_pileup_cnt;

    logic w_above;
    logic w_prev_above;
    logic w_slot_free;
    logic w_short;
    logic w_pile;

    assign w_above      = r_d > r_thr;
    assign w_prev_above = r_d_prev > r_thr;
    assign w_slot_free  = !r_peak_valid || peak_ready;
    assign w_short      = r_width < W_W'(MIN_WIDTH);
    // Width never decreases within a pulse, so checking it at pulse end is enough.
    assign w_pile       = PILEUP_EN && (r_width > W_W'(MAX_WIDTH));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_d          <= '0;
            r_d_prev     <= '0;
            r_thr        <= '0;
            r_max        <= '0;
            r_ts         <= '0;
            r_tmax       <= '0;
            r_width      <= '0;
            r_hold       <= '0;
            r_busy       <= 1'b0;
            r_peak_valid <= 1'b0;
            r_peak_amp   <= '0;
            r_peak_time  <= '0;
            r_peak_width <= '0;
            r_lost_cnt   <= '0;
            r_pileup_cnt <= '0;
        end else begin
            r_ts     <= r_ts + TS_W'(1);
            r_d      <= filter_data;
            r_thr    <= thr;
            r_d_prev <= r_d;

            // A record load below overrides this drop, giving back-to-back transfers.
            if (r_peak_valid && peak_ready) begin
                r_peak_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_above && !w_prev_above) begin
                        r_state <= S_RISE;
                        r_busy  <= 1'b1;
                        r_max   <= r_d;
                        r_tmax  <= r_ts;
                        r_width <= W_W'(1);
                    end
                end
                S_RISE: begin
                    if (w_above) begin
                        if (r_width != WIDTH_SAT) begin
                            r_width <= r_width + W_W'(1);
                        end
                        if (r_d > r_max) begin
                            r_max  <= r_d;
                            r_tmax <= r_ts;
                        end
                    end else begin
                        r_state <= S_HOLD;
                        r_hold  <= W_W'(HOLDOFF);
                        if (w_pile) begin
                            if (r_pileup_cnt != CNT_SAT) begin
                                r_pileup_cnt <= r_pileup_cnt + 8'd1;
                            end
                        end else if (!w_short) begin
                            if (w_slot_free) begin
                                r_peak_valid <= 1'b1;
                                r_peak_amp   <= r_max;
                                r_peak_time  <= r_tmax;
                                r_peak_width <= r_width;
                            end else if (r_lost_cnt != CNT_SAT) begin
                                r_lost_cnt <= r_lost_cnt + 8'd1;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (r_hold == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hold <= r_hold - W_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign peak_valid = r_peak_valid;
    assign peak_amp   = r_peak_amp;
    assign peak_time  = r_peak_time;
    assign peak_width = r_peak_width;
    assign busy       = r_busy;
    assign lost_cnt   = r_lost_cnt;
    assign pileup_cnt = r_pileup_cnt;

endmodule
